// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and address-alignment helpers for load_store_unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
  function automatic logic is_sub(input logic [1:0] size);
    return size < SZ_WORD;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size >= SZ_WORD ? |lo : (size == SZ_HALF) && lo[0];
  endfunction
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    return size >= SZ_WORD ? 2'b00 : size == SZ_HALF ? {lo[1], 1'b0} : lo;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract with sign/zero extension and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;
  always_comb begin
    sh = size == SZ_BYTE ? {lo, 3'b000} : {lo[1], 4'b0000};
    lane = 16'(word >> sh);
    mask = (size == SZ_BYTE ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    ldata = size == SZ_BYTE ? {{24{lane[7] & !uns}}, lane[7:0]} :
            size == SZ_HALF ? {{16{lane[15] & !uns}}, lane[15:0]} : word;
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: FSM load/store unit with sub-word read-modify-write; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);
  state_t      state, nxt;
  logic        we_q, uns_q, accept, mis, mem_on;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merged_q, ldata, merged;
  logic        unused_addr;
  lsu_align u_align (
    .size  (size_q),
    .uns   (uns_q),
    .lo    (addr_q[1:0]),
    .word  (mem_rd),
    .wdata (wdata_q),
    .ldata (ldata),
    .merged(merged)
  );
  assign unused_addr = ^addr_q[31:MEM_AW+2];
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP && !rst;
  assign accept = req_valid && req_ready;
  assign mem_on = !rst && (state == ACCESS || state == RMW_WR);
  assign mem_addr = mem_on ? 32'(addr_q[MEM_AW+1:2]) : '0;
  assign mem_we = mem_on && we_q && (state == RMW_WR || !is_sub(size_q));
  assign mem_wd = !mem_we ? '0 : state == RMW_WR ? merged_q : wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(req_size, req_addr[1:0]);
  always_ff @(posedge clk)
    resp_err <= rst ? 1'b0 : accept ? mis : resp_err;
`else
  assign mis = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    nxt = state == IDLE   ? (accept ? (mis ? RESP : ACCESS) : IDLE) :
          state == ACCESS ? (we_q && is_sub(size_q) ? RMW_WR : RESP) :
          state == RMW_WR ? RESP : (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= SZ_BYTE;
      addr_q <= '0;
      wdata_q <= '0;
      merged_q <= '0;
      resp_rdata <= '0;
      resp_rd <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        we_q <= req_we;
        uns_q <= req_unsigned;
        size_q <= req_size;
        addr_q <= {req_addr[31:2], align_lo(req_size, req_addr[1:0])};
        wdata_q <= req_wdata;
        resp_rd <= req_we ? '0 : req_rd;
        resp_rdata <= '0;
      end
      if (state == ACCESS) begin
        merged_q <= merged;
        if (!we_q) resp_rdata <= ldata;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0, rst, req_valid, req_ready, req_we, req_unsigned;
  logic resp_valid, resp_ready, resp_err, mem_we;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wd, mem_rd;
  logic [4:0] req_rd, resp_rd;
  typedef struct {logic [31:0] rdata; logic [4:0] rd; logic err; int lat;} exp_t;
  exp_t sb[$];
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int n_checks = 0, n_fail = 0, pulses = 0, exp_pulses = 0, cyc = 0, accept_cyc = 0;

  load_store_unit #(.MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    cyc++;
    if (mem_we === 1'b1) pulses++;
    if (mem_we === 1'b1) mem[mem_addr[9:0]] <= mem_wd;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] sz, logic uns, logic [1:0] lo);
    logic [31:0] v;
    case (sz)
      2'b00: begin v = (w >> (8 * lo)) & 32'hFF; if (!uns && v[7]) v = v | 32'hFFFFFF00; end
      2'b01: begin v = (w >> (8 * lo)) & 32'hFFFF; if (!uns && v[15]) v = v | 32'hFFFF0000; end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] st_merge(logic [31:0] w, logic [31:0] wd, logic [1:0] sz, logic [1:0] lo);
    logic [31:0] m;
    m = (sz == 2'b00 ? 32'hFF : 32'hFFFF) << (8 * lo);
    return (w & ~m) | ((wd << (8 * lo)) & m);
  endfunction

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    exp_t e;
    logic [31:0] ae;
    logic [9:0] w;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd; accept_cyc = cyc;
    ae = a;
    if (sz == 2'b01) ae[0] = 1'b0;
    else if (sz[1]) ae[1:0] = 2'b00;
    w = ae[11:2];
    e.rd = we ? 5'd0 : rd; e.err = 1'b0; e.rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (ae != a) begin e.err = 1'b1; e.lat = 1; end else
`endif
    if (we) begin
      e.lat = sz[1] ? 2 : 3;
      ref_mem[w] = sz[1] ? wd : st_merge(ref_mem[w], wd, sz, ae[1:0]);
      exp_pulses++;
    end else begin
      e.lat = 2;
      e.rdata = ld_ext(ref_mem[w], sz, uns, ae[1:0]);
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] rd,
                     output logic [31:0] rdata, output logic [4:0] rrd, output logic err, output int lat);
    issue(we, sz, uns, a, wd, rd);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rdata = resp_rdata; rrd = resp_rd; err = resp_err;
    if (resp_ready) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_rd, resp_err, mem_we, mem_wd, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b rdata=%h rd=%0d err=%b we=%b wd=%h addr=%h, expected all 0",
               req_ready, resp_valid, resp_rdata, resp_rd, resp_err, mem_we, mem_wd, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", req_ready); end
  endtask

  task automatic test_load_word;
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat; exp_t e;
    preload(10'd28, 32'h0000_0020);
    run(1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 5'd5, rdata, rd, err, lat);
    e = sb.pop_front();
    n_checks++;
    if ({rdata, rd, err, lat} !== {32'h0000_0020, 5'd5, 1'b0, 32'd2} || {e.rdata, e.rd, e.lat} !== {rdata, rd, lat}) begin
      n_fail++;
      $display("FAIL load_word: rdata=%h rd=%0d err=%b lat=%0d, expected rdata=00000020 rd=5 err=0 lat=2", rdata, rd, err, lat);
    end
  endtask

  task automatic test_load_ext;
    logic [1:0] szs [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    logic uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] adr [6] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h11, 32'h10};
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat; exp_t e;
    preload(10'd4, 32'h8000_FF80);
    for (int i = 0; i < 6; i++) begin
      run(1'b0, szs[i], uns[i], adr[i], 32'h0, 5'(i + 1), rdata, rd, err, lat);
      e = sb.pop_front();
      n_checks++;
      if ({rdata, rd, err, lat} !== {e.rdata, e.rd, e.err, e.lat}) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: rdata=%h rd=%0d err=%b lat=%0d, expected rdata=%h rd=%0d err=%b lat=%0d",
                 i, rdata, rd, err, lat, e.rdata, e.rd, e.err, e.lat);
      end
    end
    n_checks++;
    if (pulses !== exp_pulses) begin n_fail++; $display("FAIL load_no_we: pulses=%0d, expected %0d", pulses, exp_pulses); end
  endtask

  task automatic test_store;
    logic we [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] szs [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [31:0] adr [5] = '{32'h11, 32'h16, 32'h18, 32'h14, 32'h18};
    logic [31:0] wd [5] = '{32'h0000_00AB, 32'hCAFE_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0};
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat; exp_t e;
    preload(10'd4, 32'h1122_3344);
    preload(10'd5, 32'h5566_7788);
    for (int i = 0; i < 5; i++) begin
      run(we[i], szs[i], 1'b0, adr[i], wd[i], 5'd7, rdata, rd, err, lat);
      e = sb.pop_front();
      n_checks++;
      if ({rdata, rd, err, lat} !== {e.rdata, e.rd, e.err, e.lat}) begin
        n_fail++;
        $display("FAIL store[%0d]: rdata=%h rd=%0d err=%b lat=%0d, expected rdata=%h rd=%0d err=%b lat=%0d",
                 i, rdata, rd, err, lat, e.rdata, e.rd, e.err, e.lat);
      end
      n_checks++;
      if (pulses !== exp_pulses) begin n_fail++; $display("FAIL store_we[%0d]: pulses=%0d, expected %0d", i, pulses, exp_pulses); end
    end
    n_checks++;
    if ({mem[4], mem[5]} !== {32'h1122_AB44, 32'hBEEF_7788}) begin
      n_fail++;
      $display("FAIL store_mem: mem4=%h mem5=%h, expected 1122ab44 beef7788", mem[4], mem[5]);
    end
  endtask

  task automatic test_back_to_back;
    logic we [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] szs [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    logic [31:0] adr [4] = '{32'h10, 32'h12, 32'h1C, 32'h12};
    int gap [4] = '{0, 3, 4, 3};
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat, prev; exp_t e;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run(we[i], szs[i], 1'b0, adr[i], 32'h1357_9A5A, 5'd12, rdata, rd, err, lat);
      e = sb.pop_front();
      n_checks++;
      if ({rdata, rd, err, lat} !== {e.rdata, e.rd, e.err, e.lat} || (i > 0 && accept_cyc - prev != gap[i])) begin
        n_fail++;
        $display("FAIL b2b[%0d]: rdata=%h lat=%0d gap=%0d, expected rdata=%h lat=%0d gap=%0d",
                 i, rdata, lat, accept_cyc - prev, e.rdata, e.lat, gap[i]);
      end
      prev = accept_cyc;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat; exp_t e;
    resp_ready = 1'b0;
    run(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 5'd21, rdata, rd, err, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({resp_valid, req_ready, resp_rdata, resp_rd, resp_err} !== {1'b1, 1'b0, rdata, rd, err}) begin
        n_fail++;
        $display("FAIL hold[%0d]: rv=%b ready=%b rdata=%h rd=%0d, expected rv=1 ready=0 rdata=%h rd=%0d",
                 i, resp_valid, req_ready, resp_rdata, resp_rd, rdata, rd);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({resp_valid, req_ready, rdata, rd, err} !== {1'b0, 1'b1, e.rdata, e.rd, e.err}) begin
      n_fail++;
      $display("FAIL release: rv=%b ready=%b rdata=%h rd=%0d, expected rv=0 ready=1 rdata=%h rd=%0d",
               resp_valid, req_ready, rdata, rd, e.rdata, e.rd);
    end
    run(1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 5'd22, rdata, rd, err, lat);
    e = sb.pop_front();
    n_checks++;
    if ({rdata, rd, err, lat} !== {e.rdata, e.rd, e.err, e.lat}) begin
      n_fail++;
      $display("FAIL after_hold: rdata=%h lat=%0d, expected rdata=%h lat=%0d", rdata, lat, e.rdata, e.lat);
    end
  endtask

  task automatic test_misalign;
    logic we [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] szs [3] = '{2'b10, 2'b01, 2'b10};
    logic [31:0] adr [3] = '{32'h13, 32'h15, 32'h14};
    logic [31:0] rdata; logic [4:0] rd; logic err; int lat; exp_t e;
    for (int i = 0; i < 3; i++) begin
      run(we[i], szs[i], 1'b0, adr[i], 32'h0000_1234, 5'd9, rdata, rd, err, lat);
      e = sb.pop_front();
      n_checks++;
      if ({rdata, rd, err, lat} !== {e.rdata, e.rd, e.err, e.lat} || pulses !== exp_pulses) begin
        n_fail++;
        $display("FAIL misalign[%0d]: rdata=%h err=%b lat=%0d pulses=%0d, expected rdata=%h err=%b lat=%0d pulses=%0d",
                 i, rdata, err, lat, pulses, e.rdata, e.err, e.lat, exp_pulses);
      end
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    preload(10'd8, 32'h5566_7788);
    p0 = pulses;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_AAAA, 5'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: mem_we=%b, expected 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    ref_mem[8] = 32'h5566_7788;
    exp_pulses--;
    n_checks++;
    if ({pulses, mem[8]} !== {p0, 32'h5566_7788} ||
        {resp_valid, resp_rdata, resp_rd, resp_err, mem_we, mem_wd, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL abort_state: pulses=%0d mem8=%h rv=%b rdata=%h we=%b addr=%h, expected pulses=%0d mem8=55667788 outputs 0",
               pulses, mem[8], resp_valid, resp_rdata, mem_we, mem_addr, p0);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b, expected 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(negedge clk);
    test_reset;
    test_load_word;
    test_load_ext;
    test_store;
    test_back_to_back;
    test_backpressure;
    test_misalign;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
